// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle for mac_seq_ctrl: job control, operand stream, multiplier taps and result.
// master = operand source / result consumer side, slave = the controller.
interface mac_seq_ctrl_if #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    clr;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [7:0]       in_a;
    logic signed [7:0]       in_b;
    logic signed [7:0]       mul_a;
    logic signed [7:0]       mul_b;
    logic signed [15:0]      mul_p;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ovf;
    logic                    busy;

    modport master (
        output start, len, clr, in_valid, in_a, in_b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  start, len, clr, in_valid, in_a, in_b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer around an external combinational 8x8 signed multiplier.
// Define MAC_SAT_EN for a saturating accumulator with sticky overflow flag.
module mac_seq_ctrl #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    mac_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic signed [7:0]       mul_a_q, mul_a_d;
    logic signed [7:0]       mul_b_q, mul_b_d;
    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;
    logic signed [15:0]      prod_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_add;
    logic                    ovf_q, ovf_d, add_ovf;
    logic                    hs_in;

`ifdef MAC_SAT_EN
    logic signed [ACC_W:0] sum_w;

    // One guard bit is enough: |product| < 2^15 and ACC_W >= 17.
    always_comb begin
        sum_w   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){prod_q[15]}}, prod_q};
        add_ovf = sum_w[ACC_W] != sum_w[ACC_W-1];
        if (!add_ovf) begin
            acc_add = sum_w[ACC_W-1:0];
        end else if (sum_w[ACC_W]) begin
            acc_add = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_add = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_add = acc_q + {{(ACC_W-16){prod_q[15]}}, prod_q};
        add_ovf = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        v1_d    = 1'b0;
        v2_d    = v1_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        hs_in   = (state_q == StRun) && bus.in_valid;

        if (v2_q) begin
            acc_d = acc_add;
            ovf_d = ovf_q | add_ovf;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.len;
                    state_d = (bus.len != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (hs_in) begin
                    mul_a_d = bus.in_a;
                    mul_b_d = bus.in_b;
                    v1_d    = 1'b1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            // Last product is in stage 3 exactly when v2 is set and nothing follows it.
            StDrain: begin
                if (v2_q && !v1_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.clr) begin
            state_d = StIdle;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            acc_d   = acc_q;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            prod_q  <= bus.mul_p;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StRun);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for the shared 8x8 signed multiplier of the MAC unit. It accepts one dot-product job at a time: a length plus a stream of operand pairs. Each pair is pipelined through the external multiplier, the products are accumulated into a wide register, and one result is returned on a valid/ready output. It sits between the operand source (buffer or DMA) and the MAC result consumer. The multiplier itself stays combinational and outside this block.

## Interface
- ACC_W, 24, accumulator/result width in bits, signed; legal range 17..32
- LEN_W, 8, job length width; maximum job length is 2^LEN_W-1 pairs
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request, sampled only in IDLE
- len  in  LEN_W  number of operand pairs, sampled with start
- clr  in  1  synchronous abort; pipeline is discarded and the block returns to IDLE
- in_valid / in_ready  in / out  1  operand handshake
- in_a, in_b  in  8  signed operands
- mul_a, mul_b  out  8  registered operands to the multiplier
- mul_p  in  16  signed product from the multiplier (combinational from mul_a/mul_b)
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  ACC_W  signed dot product
- out_ovf  out  1  sticky overflow flag for the job
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1, len!=0: latch len into the remaining-issue counter, clear acc and out_ovf, go to RUN.
  - start=1, len=0: clear acc, go to DONE.
  - start=0: stay in IDLE.
- RUN:
  - in_ready=1.
  - On a handshake: mul_a<=in_a, mul_b<=in_b, v1<=1, counter decrements.
  - On the handshake with counter==1, go to DRAIN. in_ready is 0 from the next cycle onward.
  - Bubbles (in_valid=0) are allowed. On a bubble, v1<=0.
- Pipeline:
  - Stage 2: prod_q<=mul_p, v2<=v1.
  - Stage 3: when v2=1, acc<=acc+sign_ext(prod_q).
- DRAIN: go to DONE on the same edge that performs the final accumulate (v2=1 and v1=0).
- DONE:
  - out_valid=1. out_data=acc and out_ovf are held stable until out_ready=1.
  - On the out_valid and out_ready handshake, go to IDLE.
- start is ignored outside IDLE.
- clr has priority over every other event. On the next edge: state=IDLE, v1=v2=0, out_valid=0, in_ready=0; acc is left as is.
- Arithmetic:
  - Operands and product are two's complement.
  - The product is sign-extended to ACC_W.
  - At the default widths no overflow is possible: 255 x 16384 < 2^23.

## Timing
- Reset values: state IDLE, in_ready 0, out_valid 0, out_data 0, out_ovf 0, busy 0, mul_a 0, mul_b 0, v1 0, v2 0, counter 0.
- Reset mid-job takes effect asynchronously. Any in-flight job is lost.
- start in cycle S moves the block to RUN; in_ready=1 from cycle S+1.
- With len=0, out_valid=1 in cycle S+1.
- If the last operand handshake occurs in cycle T, out_valid=1 first in cycle T+3.
- Throughput: one pair per cycle. Job overhead is 1 start cycle + 3 drain cycles + the output handshake.
- out_valid=1 with out_ready=0: out_data and out_ovf hold indefinitely.
- A start asserted in the same cycle as the output handshake is ignored; a new start is accepted from the next cycle.

## Configuration
- MAC_SAT_EN defined:
  - Stage 3 saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - out_ovf is set whenever a clamp occurs and stays set until the next start.
- MAC_SAT_EN undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - out_ovf is tied to 0.

## Test plan
- Bench connects an ideal signed 8x8 multiplier to mul_*. Defaults, back-to-back: len=4, pairs (3,5), (-2,7), (127,127), (-128,-128) -> out_data=32514, out_valid exactly 3 cycles after the 4th handshake, in_ready low from the cycle after the 4th handshake.
- start with len=0 -> out_valid=1 the next cycle, out_data=0, no in_ready pulse.
- len=3, pairs (10,10), (-1,1), (5,-5), with 2-cycle in_valid gaps and out_ready held low for 5 cycles -> out_data=74 held stable throughout; a start pulse during DONE is ignored and busy stays 1.
- ACC_W=17, len=8, every pair (-128,-128) -> with MAC_SAT_EN: out_data=65535, out_ovf=1. Without MAC_SAT_EN: out_data=0, out_ovf=0.
- rst_n pulsed low during RUN after 2 of 5 pairs -> all outputs take their reset values immediately; a new len=2 job with (2,3), (4,5) -> 26.
- clr asserted during DRAIN -> next cycle IDLE, out_valid never rises; a following len=1 job with (-7,9) -> -63.
